// File: rtl/sdhci_pkg.sv
// sdhci_pkg: shared types for the SDHCI command arbiter.
// Error bundle, Auto CMD12 status bit positions, arbiter states.
package sdhci_pkg;

  typedef struct packed {
    logic index;
    logic endbit;
    logic crc;
    logic timeout;
  } cmd_err_t;

  localparam int unsigned A12ErrNotExec   = 0;
  localparam int unsigned A12ErrTimeout   = 1;
  localparam int unsigned A12ErrCrc       = 2;
  localparam int unsigned A12ErrEndBit    = 3;
  localparam int unsigned A12ErrIndex     = 4;
  localparam int unsigned A12ErrNotIssued = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRV_ISSUE,
    ST_DRV_WAIT,
    ST_A12_ISSUE,
    ST_A12_WAIT
  } arb_state_e;

endpackage

// File: rtl/sdhci_cmd_arbiter.sv
// sdhci_cmd_arbiter: shares the CMD sequencer between driver and Auto CMD12.
// Ports: drv_* (driver req/status), a12_* (Auto CMD12), seq_* (sequencer).
module sdhci_cmd_arbiter
  import sdhci_pkg::*;
#(
  parameter logic [5:0] Acmd12Index    = 6'd12,
  parameter logic [1:0] Acmd12RespType = 2'b11
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        drv_valid_i,
  input  logic [5:0]  drv_index_i,
  input  logic [31:0] drv_arg_i,
  input  logic [1:0]  drv_resp_type_i,
  input  logic        drv_crc_chk_i,
  input  logic        drv_idx_chk_i,
  output logic        drv_inhibit_o,
  output logic        drv_done_o,
  output logic [3:0]  drv_err_o,
  input  logic        a12_req_i,
  input  logic [31:0] a12_arg_i,
  output logic        a12_busy_o,
  output logic [7:0]  a12_err_o,
  output logic        seq_start_o,
  output logic [5:0]  seq_index_o,
  output logic [31:0] seq_arg_o,
  output logic [1:0]  seq_resp_type_o,
  output logic        seq_crc_chk_o,
  output logic        seq_idx_chk_o,
  input  logic        seq_done_i,
  input  logic [3:0]  seq_err_i
);

  arb_state_e  state_q, state_d;
  logic        drv_pend_q, drv_pend_d;
  logic        a12_pend_q, a12_pend_d;

  logic [5:0]  drv_index_q;
  logic [31:0] drv_arg_q;
  logic [1:0]  drv_rtype_q;
  logic        drv_crc_q;
  logic        drv_ichk_q;

  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [1:0]  rtype_q, rtype_d;
  logic        crc_q, crc_d;
  logic        ichk_q, ichk_d;

  cmd_err_t    err;
  logic        any_err;
  logic        drv_accept;

  assign err     = cmd_err_t'(seq_err_i);
  assign any_err = |seq_err_i;

  assign drv_inhibit_o = drv_pend_q
                       | (state_q == ST_DRV_ISSUE)
                       | (state_q == ST_DRV_WAIT);
  assign a12_busy_o    = a12_pend_q
                       | (state_q == ST_A12_ISSUE)
                       | (state_q == ST_A12_WAIT);

  // The register file already blocks writes under inhibit.
  assign drv_accept = drv_valid_i & ~drv_inhibit_o;

  assign seq_index_o     = idx_q;
  assign seq_arg_o       = arg_q;
  assign seq_resp_type_o = rtype_q;
  assign seq_crc_chk_o   = crc_q;
  assign seq_idx_chk_o   = ichk_q;

  always_comb begin
    state_d     = state_q;
    drv_pend_d  = drv_pend_q;
    a12_pend_d  = a12_pend_q;
    idx_d       = idx_q;
    arg_d       = arg_q;
    rtype_d     = rtype_q;
    crc_d       = crc_q;
    ichk_d      = ichk_q;
    seq_start_o = 1'b0;
    drv_done_o  = 1'b0;
    drv_err_o   = 4'b0;
    a12_err_o   = 8'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Auto CMD12 wins a tie.
        if (a12_pend_q) begin
          state_d = ST_A12_ISSUE;
          idx_d   = Acmd12Index;
          arg_d   = a12_arg_i;
          rtype_d = Acmd12RespType;
          crc_d   = 1'b1;
          ichk_d  = 1'b1;
        end else if (drv_pend_q) begin
          state_d = ST_DRV_ISSUE;
          idx_d   = drv_index_q;
          arg_d   = drv_arg_q;
          rtype_d = drv_rtype_q;
          crc_d   = drv_crc_q;
          ichk_d  = drv_ichk_q;
        end
      end
      ST_DRV_ISSUE: begin
        seq_start_o = 1'b1;
        state_d     = ST_DRV_WAIT;
      end
      ST_DRV_WAIT: begin
        if (seq_done_i) begin
          drv_done_o = 1'b1;
          drv_err_o  = seq_err_i;
          drv_pend_d = 1'b0;
          if (any_err && a12_pend_q) begin
            a12_pend_d = 1'b0;
            a12_err_o[A12ErrNotExec] = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      ST_A12_ISSUE: begin
        seq_start_o = 1'b1;
        state_d     = ST_A12_WAIT;
      end
      ST_A12_WAIT: begin
        if (seq_done_i) begin
          a12_err_o[A12ErrIndex]   = err.index;
          a12_err_o[A12ErrEndBit]  = err.endbit;
          a12_err_o[A12ErrCrc]     = err.crc;
          a12_err_o[A12ErrTimeout] = err.timeout;
          a12_pend_d = 1'b0;
          // Queued driver command is dropped, not reported as done.
          if (any_err && drv_pend_q) begin
            drv_pend_d = 1'b0;
            a12_err_o[A12ErrNotIssued] = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new request beats a same-cycle completion.
    if (drv_accept) drv_pend_d = 1'b1;
    if (a12_req_i)  a12_pend_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      drv_pend_q <= 1'b0;
      a12_pend_q <= 1'b0;
      idx_q      <= '0;
      arg_q      <= '0;
      rtype_q    <= '0;
      crc_q      <= 1'b0;
      ichk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      drv_pend_q <= drv_pend_d;
      a12_pend_q <= a12_pend_d;
      idx_q      <= idx_d;
      arg_q      <= arg_d;
      rtype_q    <= rtype_d;
      crc_q      <= crc_d;
      ichk_q     <= ichk_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drv_index_q <= '0;
      drv_arg_q   <= '0;
      drv_rtype_q <= '0;
      drv_crc_q   <= 1'b0;
      drv_ichk_q  <= 1'b0;
    end else if (drv_accept) begin
      drv_index_q <= drv_index_i;
      drv_arg_q   <= drv_arg_i;
      drv_rtype_q <= drv_resp_type_i;
      drv_crc_q   <= drv_crc_chk_i;
      drv_ichk_q  <= drv_idx_chk_i;
    end
  end

endmodule

// File: tb/tb_sdhci_cmd_arbiter.sv
// tb_sdhci_cmd_arbiter: scoreboard bench for sdhci_cmd_arbiter.
// Directed requests, sequencer model, decoupled output monitor.
module tb_sdhci_cmd_arbiter;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [1:0]  rt;
    logic        crc;
    logic        ichk;
  } start_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        drv_valid_i = 1'b0;
  logic [5:0]  drv_index_i = '0;
  logic [31:0] drv_arg_i = '0;
  logic [1:0]  drv_resp_type_i = '0;
  logic        drv_crc_chk_i = 1'b0;
  logic        drv_idx_chk_i = 1'b0;
  logic        drv_inhibit_o;
  logic        drv_done_o;
  logic [3:0]  drv_err_o;
  logic        a12_req_i = 1'b0;
  logic [31:0] a12_arg_i = 32'h0000_0000;
  logic        a12_busy_o;
  logic [7:0]  a12_err_o;
  logic        seq_start_o;
  logic [5:0]  seq_index_o;
  logic [31:0] seq_arg_o;
  logic [1:0]  seq_resp_type_o;
  logic        seq_crc_chk_o;
  logic        seq_idx_chk_o;
  logic        seq_done_i = 1'b0;
  logic [3:0]  seq_err_i = '0;

  sdhci_cmd_arbiter dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .drv_valid_i     (drv_valid_i),
    .drv_index_i     (drv_index_i),
    .drv_arg_i       (drv_arg_i),
    .drv_resp_type_i (drv_resp_type_i),
    .drv_crc_chk_i   (drv_crc_chk_i),
    .drv_idx_chk_i   (drv_idx_chk_i),
    .drv_inhibit_o   (drv_inhibit_o),
    .drv_done_o      (drv_done_o),
    .drv_err_o       (drv_err_o),
    .a12_req_i       (a12_req_i),
    .a12_arg_i       (a12_arg_i),
    .a12_busy_o      (a12_busy_o),
    .a12_err_o       (a12_err_o),
    .seq_start_o     (seq_start_o),
    .seq_index_o     (seq_index_o),
    .seq_arg_o       (seq_arg_o),
    .seq_resp_type_o (seq_resp_type_o),
    .seq_crc_chk_o   (seq_crc_chk_o),
    .seq_idx_chk_o   (seq_idx_chk_o),
    .seq_done_i      (seq_done_i),
    .seq_err_i       (seq_err_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int seq_lat = 4;

  start_t     exp_start_q[$];
  logic [3:0] exp_done_q[$];
  logic [7:0] exp_a12_q[$];
  logic [3:0] resp_q[$];

  start_t     m_exp;
  logic [3:0] m_derr;
  logic [7:0] m_aerr;
  logic [3:0] s_err;
  bit         s_abort;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output event must match the head of its queue.
  always @(negedge clk) begin
    if (seq_start_o) begin
      if (exp_start_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL start_extra: got index %0d want none",
                 seq_index_o);
      end else begin
        m_exp = exp_start_q.pop_front();
        chk("start_payload",
            {seq_index_o, seq_arg_o, seq_resp_type_o,
             seq_crc_chk_o, seq_idx_chk_o}, m_exp);
      end
    end
    if (drv_done_o) begin
      if (exp_done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_extra: got err %b want no done",
                 drv_err_o);
      end else begin
        m_derr = exp_done_q.pop_front();
        chk("drv_err", drv_err_o, m_derr);
      end
    end else if (drv_err_o != 4'b0) begin
      checks++;
      errors++;
      $display("FAIL drv_err_nodone: got %b want 0", drv_err_o);
    end
    if (a12_err_o != 8'b0) begin
      if (exp_a12_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a12_err_extra: got %b want 0", a12_err_o);
      end else begin
        m_aerr = exp_a12_q.pop_front();
        chk("a12_err", a12_err_o, m_aerr);
      end
    end
  end

  // Sequencer model: answers each start after seq_lat cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (seq_start_o) begin
        s_err = (resp_q.size() != 0) ? resp_q.pop_front() : 4'h0;
        s_abort = 1'b0;
        for (int k = 0; k < seq_lat; k++) begin
          @(posedge clk);
          if (!rst_ni) begin
            s_abort = 1'b1;
            break;
          end
        end
        if (!s_abort) begin
          #1;
          seq_done_i = 1'b1;
          seq_err_i  = s_err;
          @(posedge clk);
          #1;
          seq_done_i = 1'b0;
          seq_err_i  = 4'h0;
        end
      end
    end
  end

  task automatic set_drv(input logic [5:0] i, input logic [31:0] a,
                         input logic [1:0] r, input logic c,
                         input logic x);
    drv_index_i     = i;
    drv_arg_i       = a;
    drv_resp_type_i = r;
    drv_crc_chk_i   = c;
    drv_idx_chk_i   = x;
    drv_valid_i     = 1'b1;
  endtask

  task automatic drv_cmd(input logic [5:0] i, input logic [31:0] a,
                         input logic [1:0] r, input logic c,
                         input logic x);
    set_drv(i, a, r, c, x);
    tick();
    drv_valid_i = 1'b0;
  endtask

  task automatic a12_pulse();
    a12_req_i = 1'b1;
    tick();
    a12_req_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((drv_inhibit_o || a12_busy_o) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (drv_inhibit_o || a12_busy_o) begin
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles want idle",
               name, n);
    end
    repeat (3) tick();
    chk({name, "_queues"},
        exp_start_q.size() + exp_done_q.size() + exp_a12_q.size(),
        0);
  endtask

  function automatic start_t a12s();
    return '{idx: 6'd12, arg: 32'h0, rt: 2'b11, crc: 1'b1, ichk: 1'b1};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_outputs",
        {drv_inhibit_o, a12_busy_o, seq_start_o, drv_done_o,
         drv_err_o, a12_err_o}, 0);
    chk("rst_payload",
        {seq_index_o, seq_arg_o, seq_resp_type_o,
         seq_crc_chk_o, seq_idx_chk_o}, 0);
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (2) tick();

    // 1: simultaneous, CMD12 first then CMD26, both clean
    exp_start_q.push_back(a12s());
    exp_start_q.push_back('{6'd26, 32'h1234_5678, 2'b01, 1'b1, 1'b1});
    resp_q.push_back(4'h0);
    resp_q.push_back(4'h0);
    exp_done_q.push_back(4'b0000);
    set_drv(6'd26, 32'h1234_5678, 2'b01, 1'b1, 1'b1);
    a12_req_i = 1'b1;
    tick();
    drv_valid_i = 1'b0;
    a12_req_i   = 1'b0;
    chk("t1_flags", {drv_inhibit_o, a12_busy_o}, 2'b11);
    wait_idle("t1");

    // 2: CMD12 with crc+index error cancels queued driver cmd
    exp_start_q.push_back(a12s());
    resp_q.push_back(4'b1010);
    exp_a12_q.push_back(8'b1001_0100);
    a12_pulse();
    repeat (4) tick();
    drv_cmd(6'd26, 32'hCAFE_0001, 2'b01, 1'b1, 1'b1);
    wait_idle("t2");
    repeat (80) tick();
    chk("t2_inhibit", drv_inhibit_o, 1'b0);

    // 3: driver error cancels pending CMD12
    exp_start_q.push_back('{6'd18, 32'h0000_0400, 2'b01, 1'b1, 1'b0});
    resp_q.push_back(4'b1010);
    exp_done_q.push_back(4'b1010);
    exp_a12_q.push_back(8'b0000_0001);
    drv_cmd(6'd18, 32'h0000_0400, 2'b01, 1'b1, 1'b0);
    repeat (4) tick();
    a12_pulse();
    wait_idle("t3");
    chk("t3_busy", a12_busy_o, 1'b0);

    // 4: driver-only timeout, plus issue latency
    exp_start_q.push_back('{6'd17, 32'h8765_4321, 2'b10, 1'b0, 1'b1});
    resp_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0001);
    drv_cmd(6'd17, 32'h8765_4321, 2'b10, 1'b0, 1'b1);
    chk("t4_lat1", {seq_start_o, drv_inhibit_o}, 2'b01);
    tick();
    chk("t4_lat2", {seq_start_o, seq_index_o}, {1'b1, 6'd17});
    wait_idle("t4");

    // 5: second write under inhibit is ignored
    exp_start_q.push_back('{6'd24, 32'h0000_1111, 2'b01, 1'b1, 1'b1});
    resp_q.push_back(4'h0);
    exp_done_q.push_back(4'b0000);
    drv_cmd(6'd24, 32'h0000_1111, 2'b01, 1'b1, 1'b1);
    tick();
    drv_cmd(6'd25, 32'h0000_2222, 2'b00, 1'b0, 1'b0);
    wait_idle("t5");

    // 6: async reset during A12_WAIT
    seq_lat = 40;
    exp_start_q.push_back(a12s());
    resp_q.push_back(4'h0);
    a12_pulse();
    repeat (3) tick();
    chk("t6_busy_pre", {a12_busy_o, seq_idx_chk_o}, 2'b11);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_flags",
        {drv_inhibit_o, a12_busy_o, seq_start_o, drv_done_o,
         drv_err_o, a12_err_o}, 0);
    chk("t6_rst_payload",
        {seq_index_o, seq_arg_o, seq_resp_type_o,
         seq_crc_chk_o, seq_idx_chk_o}, 0);
    repeat (3) tick();
    seq_lat = 4;
    rst_ni = 1'b1;
    repeat (20) tick();
    chk("t6_after", {a12_busy_o, drv_inhibit_o}, 2'b00);
    chk("t6_queues",
        exp_start_q.size() + exp_done_q.size() + exp_a12_q.size(),
        0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
